mp_grf: RTL and testbench

MP_GRF -- requirements
Module: mp_grf

---
 rtl/mp_grf_pkg.sv | 15 +
 rtl/mp_grf_scoreboard.sv | 49 ++++
 rtl/mp_grf.sv | 126 ++++++++++++
 tb/tb_mp_grf.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_grf_pkg.sv
// Shared types and default sizing for the mp_grf register file.
// The clear-sweep FSM state type lives here so the top and any tooling agree on encoding.
package mp_grf_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NRD      = 3;
  localparam int DEF_ZERO_REG = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/mp_grf_scoreboard.sv
// Pending-result bits: one per entry, set by allocation and cleared by writes or the sweep.
// Lookups present registered state only.
module mp_grf_scoreboard
  import mp_grf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_en_i,
  input  logic [ADDR_W-1:0]     alloc_addr_i,
  input  logic                  clr0_en_i,
  input  logic [ADDR_W-1:0]     clr0_addr_i,
  input  logic                  clr1_en_i,
  input  logic [ADDR_W-1:0]     clr1_addr_i,
  input  logic                  sweep_en_i,
  input  logic [ADDR_W-1:0]     sweep_addr_i,
  input  logic [NRD*ADDR_W-1:0] lk_addr_i,
  output logic [NRD-1:0]        lk_pend_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Allocation is applied last so it wins over a same-cycle write clear.
  always_comb begin
    pend_d = pend_q;
    if (clr0_en_i)  pend_d[clr0_addr_i]  = 1'b0;
    if (clr1_en_i)  pend_d[clr1_addr_i]  = 1'b0;
    if (sweep_en_i) pend_d[sweep_addr_i] = 1'b0;
    if (alloc_en_i) pend_d[alloc_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    lk_pend_o = '0;
    for (int k = 0; k < NRD; k++) begin
      lk_pend_o[k] = pend_q[lk_addr_i[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/mp_grf.sv
// Multi-ported general register file: two write ports (port 1 has priority), NRD bypassed
// combinational read ports, per-entry pending scoreboard and a one-entry-per-cycle clear sweep.
module mp_grf
  import mp_grf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                clr_busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                idle;
  logic                sweep;
  logic                wr0_ok;
  logic                wr1_ok;
  logic                alloc_ok;
  logic [ADDR_W-1:0]   ra;

  assign idle  = (state_q == ST_IDLE);
  assign sweep = (state_q == ST_CLEAR);

  // Entry 0 is hardwired to zero when ZERO_REG is set, so it never accepts writes or allocs.
  assign wr0_ok   = we0      && idle && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok   = we1      && idle && !((ZERO_REG != 0) && (wa1 == '0));
  assign alloc_ok = alloc_en && idle && !((ZERO_REG != 0) && (alloc_addr == '0));

  // Port 1 is written after port 0 so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (sweep) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (wr0_ok) mem_q[wa0] <= wd0;
      if (wr1_ok) mem_q[wa1] <= wd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            idx_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Hold the index at the last entry rather than wrapping back to 0.
          if (idx_q == '1) begin
            state_q    <= ST_IDLE;
            clr_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;

  // Bypass terms reuse wr*_ok, which already excludes the sweep and entry 0.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (ra == '0))   rd_data[k*DATA_W +: DATA_W] = '0;
      else if (wr1_ok && (wa1 == ra))      rd_data[k*DATA_W +: DATA_W] = wd1;
      else if (wr0_ok && (wa0 == ra))      rd_data[k*DATA_W +: DATA_W] = wd0;
      else                                 rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
    end
  end

  mp_grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en_i   (alloc_ok),
    .alloc_addr_i (alloc_addr),
    .clr0_en_i    (wr0_ok),
    .clr0_addr_i  (wa0),
    .clr1_en_i    (wr1_ok),
    .clr1_addr_i  (wa1),
    .sweep_en_i   (sweep),
    .sweep_addr_i (idx_q),
    .lk_addr_i    (rd_addr),
    .lk_pend_o    (rd_pend)
  );

endmodule

// File: tb/tb_mp_grf.sv
// Directed self-checking bench for mp_grf with hand-computed expectations.
module tb_mp_grf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 3;
  localparam int DEPTH  = 32;

  logic                  clk;
  logic                  rst_n;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_pend;
  logic                  we0, we1, alloc_en, clr_req, clr_busy;
  logic [ADDR_W-1:0]     wa0, wa1, alloc_addr;
  logic [DATA_W-1:0]     wd0, wd1;

  int n_chk;
  int n_fail;

  mp_grf #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pend    (rd_pend),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
    rd_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [DATA_W-1:0] rdd(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    int cnt;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rd_addr = '0;
    wa0 = '0; wa1 = '0; alloc_addr = '0;
    wd0 = '0; wd1 = '0;
    idle_inputs();

    // Reset state
    set_rd(0, 5'd3); set_rd(1, 5'd7); set_rd(2, 5'd9);
    #2;
    check("rst_busy", clr_busy, 0);
    check("rst_rd0", rdd(0), 0);
    check("rst_rd1", rdd(1), 0);
    check("rst_pend", rd_pend, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rd2", rdd(2), 0);
    check("post_rst_pend", rd_pend, 0);

    // Basic write then read
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234_5678;
    tick();
    we0 = 1'b0;
    set_rd(0, 5'd3);
    #1;
    check("wr3_rd", rdd(0), 32'h1234_5678);

    // Same-address collision, port 1 wins, bypass in same cycle
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_AAAA;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_5555;
    set_rd(1, 5'd7); set_rd(2, 5'd3);
    #1;
    check("coll_byp", rdd(1), 32'h0000_5555);
    check("coll_other", rdd(2), 32'h1234_5678);
    tick();
    idle_inputs();
    #1;
    check("coll_store", rdd(1), 32'h0000_5555);

    // Port-0-only bypass
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_BEEF;
    set_rd(2, 5'd10);
    #1;
    check("byp0", rdd(2), 32'h0000_BEEF);
    tick();
    we0 = 1'b0;
    #1;
    check("byp0_store", rdd(2), 32'h0000_BEEF);

    // Zero register
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    set_rd(0, 5'd0);
    #1;
    check("zero_same", rdd(0), 0);
    tick();
    idle_inputs();
    #1;
    check("zero_next", rdd(0), 0);

    // Pending scoreboard
    alloc_en = 1'b1; alloc_addr = 5'd9;
    set_rd(0, 5'd9);
    #1;
    check("pend_no_byp", rd_pend[0], 0);
    tick();
    alloc_en = 1'b0;
    #1;
    check("pend_set", rd_pend[0], 1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0099;
    #1;
    check("pend_hold", rd_pend[0], 1);
    tick();
    we0 = 1'b0;
    #1;
    check("pend_clr", rd_pend[0], 0);
    check("pend_data", rdd(0), 32'h0000_0099);
    alloc_en = 1'b1; alloc_addr = 5'd9;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0077;
    tick();
    idle_inputs();
    #1;
    check("alloc_wins", rd_pend[0], 1);
    check("alloc_wr_data", rdd(0), 32'h0000_0077);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    alloc_en = 1'b0;
    set_rd(1, 5'd0);
    #1;
    check("alloc0_pend", rd_pend[1], 0);

    // Fill, then sweep
    for (int i = 1; i < DEPTH; i++) begin
      we0 = 1'b1; wa0 = ADDR_W'(i); wd0 = 32'hA500_0000 | i;
      tick();
    end
    we0 = 1'b0;
    set_rd(0, 5'd31);
    #1;
    check("fill31", rdd(0), 32'hA500_001F);
    clr_req = 1'b1;
    #1;
    check("busy_pre", clr_busy, 0);
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      cnt++;
      if (cnt == 11) begin
        // index 10 this cycle: entry 5 already cleared, entry 31 not yet
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_0055;
        alloc_en = 1'b1; alloc_addr = 5'd5;
        set_rd(0, 5'd5); set_rd(1, 5'd31);
        #1;
        check("sweep_nobyp", rdd(0), 0);
        check("sweep_mid31", rdd(1), 32'hA500_001F);
      end
      if (cnt == 12) idle_inputs();
      if (cnt == 21) clr_req = 1'b1;
      if (cnt == 22) clr_req = 1'b0;
      tick();
    end
    idle_inputs();
    check("busy_cycles", cnt, DEPTH);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(0, ADDR_W'(i));
      #1;
      check($sformatf("swept_rd%0d", i), rdd(0), 0);
      check($sformatf("swept_pend%0d", i), rd_pend[0], 0);
    end
    tick();
    check("idle_after", clr_busy, 0);

    // Reset in the middle of a sweep
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h0000_2020;
    alloc_en = 1'b1; alloc_addr = 5'd25;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    set_rd(0, 5'd20); set_rd(1, 5'd25);
    #1;
    check("mid_busy", clr_busy, 1);
    check("mid_rd20", rdd(0), 32'h0000_2020);
    check("mid_pend25", rd_pend[1], 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", clr_busy, 0);
    check("abort_rd20", rdd(0), 0);
    check("abort_pend25", rd_pend[1], 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_busy", clr_busy, 0);
    we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h0000_1212;
    tick();
    we0 = 1'b0;
    set_rd(2, 5'd12);
    #1;
    check("rel_idle_wr", rdd(2), 32'h0000_1212);
    check("rel_busy2", clr_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
